// File: rtl/mlop_pkg.sv
// mlop_pkg: shared constants for the multi-operand adder controller.
//   - Default widths: operand (XW_DEF), accumulator/result (AW_DEF),
//     term count (CW_DEF).
//   - FSM state codes for mlop_seq_ctrl (2-bit, legacy-compatible values).
package mlop_pkg;

    localparam int unsigned XW_DEF = 10;
    localparam int unsigned AW_DEF = 16;
    localparam int unsigned CW_DEF = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/mlop_seq_ctrl_rgst.sv
// rgst: generic W-bit register with synchronous clear and load.
//   clk   in  clock, rising edge
//   rst_b in  asynchronous active-low reset (q -> 0)
//   clr   in  synchronous clear; takes priority over ld
//   ld    in  load d into q
//   d     in  W-bit data
//   q     out W-bit registered value
module rgst #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mlop_seq_ctrl.sv
// mlop_seq_ctrl: sequencing controller + accumulator for multi-operand
// addition. A job (start + n) clears the sum, then exactly n operands are
// pulled over a valid/ready handshake and added; done pulses once with the
// final sum held until the next job.
//   clk     in  clock, rising edge
//   rst_b   in  asynchronous active-low reset
//   start   in  job request, sampled only in IDLE
//   n       in  CW-bit operand count, sampled with start
//   x_valid in  operand present on x
//   x       in  XW-bit unsigned operand
//   x_ready out operand accepted this cycle (decoded from state)
//   busy    out job in progress (decoded from state)
//   done    out one-cycle registered pulse: result final
//   sum     out AW-bit registered sum, modulo 2^AW
//   ovf     out sticky carry-out of bit AW-1 during the current job
module mlop_seq_ctrl
    import mlop_pkg::*;
#(
    parameter int unsigned XW = XW_DEF,
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          start,
    input  logic [CW-1:0] n,
    input  logic          x_valid,
    input  logic [XW-1:0] x,
    output logic          x_ready,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] sum,
    output logic          ovf
);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] cnt;
    logic          take;
    logic          hs;
    logic [AW:0]   ext;

    assign x_ready = (state == S_ACC);
    assign busy    = (state == S_ACC);
    assign take    = (state == S_IDLE) && start;
    assign hs      = x_valid && x_ready;

    // One extra bit on top of the sum captures the carry for ovf.
    assign ext = {1'b0, sum} + {{(AW + 1 - XW){1'b0}}, x};

    rgst #(.W(AW)) u_acc (
        .clk   (clk),
        .rst_b (rst_b),
        .clr   (take),
        .ld    (hs),
        .d     (ext[AW-1:0]),
        .q     (sum)
    );

    // take and hs are mutually exclusive (different states), so one load
    // port serves both the initial count and each decrement.
    rgst #(.W(CW)) u_cnt (
        .clk   (clk),
        .rst_b (rst_b),
        .clr   (1'b0),
        .ld    (take || hs),
        .d     (take ? n : cnt - CW'(1)),
        .q     (cnt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (n == '0) ? S_DONE : S_ACC;
                end
            end
            S_ACC: begin
                if (hs && (cnt == CW'(1))) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= S_IDLE;
            done  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state_nxt == S_DONE);
            if (take) begin
                ovf <= 1'b0;
            end else if (hs) begin
                ovf <= ovf | ext[AW];
            end
        end
    end

endmodule

// File: tb/tb_mlop_seq_ctrl.sv
module tb_mlop_seq_ctrl;

    localparam int XW = 10;
    localparam int AW = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] n = '0;
    logic          x_valid = 1'b0;
    logic [XW-1:0] x = '0;
    logic          x_ready;
    logic          busy;
    logic          done;
    logic [AW-1:0] sum;
    logic          ovf;

    mlop_seq_ctrl #(.XW(XW), .AW(AW), .CW(CW)) dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .start   (start),
        .n       (n),
        .x_valid (x_valid),
        .x       (x),
        .x_ready (x_ready),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string name, input longint act, input longint exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a job is "remaining operands"; integer sum, wrap by modulo.
    bit m_active = 0;
    bit m_done = 0;
    int m_left = 0;
    longint m_sum = 0;
    bit m_ovf = 0;
    int op_idx = 0;
    int ops[256];

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            m_active = 0; m_done = 0; m_left = 0; m_sum = 0; m_ovf = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_active) begin
            if (x_valid === 1'b1) begin
                longint t;
                t = m_sum + longint'(x);
                if (t >= 65536) m_ovf = 1;
                m_sum = t % 65536;
                m_left--;
                op_idx++;
                if (m_left == 0) begin
                    m_active = 0;
                    m_done = 1;
                end
            end
        end else if (start === 1'b1) begin
            m_sum = 0; m_ovf = 0; op_idx = 0;
            if (n == 0) m_done = 1;
            else begin
                m_active = 1;
                m_left = int'(n);
            end
        end
    end

    // Compare process: outputs against the model every cycle out of reset.
    always @(negedge clk) begin
        if (rst_b) begin
            check("busy", busy, m_active);
            check("x_ready", x_ready, m_active);
            check("done", done, m_done);
            check("sum", sum, m_sum);
            check("ovf", ovf, m_ovf);
        end
    end

    // Operand source: 0 = valid held high, 1 = toggling, 2 = random.
    int vmode = 0;
    bit phase = 0;
    always @(negedge clk) begin
        phase = ~phase;
        case (vmode)
            0: x_valid = 1'b1;
            1: x_valid = phase;
            default: x_valid = ($urandom_range(0, 99) < 60);
        endcase
        x = XW'(ops[op_idx & 255]);
    end

    task automatic pulse_start(input int nn);
        @(negedge clk);
        start = 1'b1;
        n = CW'(nn);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns the number of cycles from the start edge to the done cycle.
    task automatic wait_done(input bit poke_done, output int cyc);
        cyc = 1;
        while (!m_done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("done_timeout", m_done, 1);
        if (poke_done) begin
            start = 1'b1;
            n = CW'(7);
        end
        @(negedge clk);
        start = 1'b0;
        check("idle_after_done", busy, 0);
    endtask

    task automatic run_job(input int nn, input int mode, input bit poke_done, output int cyc);
        vmode = mode;
        pulse_start(nn);
        wait_done(poke_done, cyc);
    endtask

    initial begin
        int cyc;
        int k;
        #12;
        check("rst_sum", sum, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_xready", x_ready, 0);
        rst_b = 1'b1;

        // n=199, x=1,4,7,... with valid held high
        for (int i = 0; i < 256; i++) ops[i] = 1 + 3 * i;
        run_job(199, 0, 0, cyc);
        check("t1_cycles", cyc, 200);
        check("t1_sum", sum, 59302);
        check("t1_model_sum", m_sum, 59302);
        check("t1_ovf", ovf, 0);

        // same job, toggling valid
        run_job(199, 1, 0, cyc);
        check("t2_sum", sum, 59302);
        check("t2_slow", (cyc >= 390) ? 1 : 0, 1);

        // n=0, with a start poked during DONE
        run_job(0, 0, 1, cyc);
        check("t3_cycles", cyc, 1);
        check("t3_sum", sum, 0);
        repeat (3) @(negedge clk);
        check("t3_no_relaunch", busy, 0);

        // overflow: 65 x 1023
        for (int i = 0; i < 256; i++) ops[i] = 1023;
        run_job(65, 2, 0, cyc);
        check("t4_sum", sum, 959);
        check("t4_ovf", ovf, 1);
        ops[0] = 5;
        run_job(1, 0, 0, cyc);
        check("t4b_sum", sum, 5);
        check("t4b_ovf", ovf, 0);

        // mid-job reset after 50 operands
        for (int i = 0; i < 256; i++) ops[i] = 1 + 3 * i;
        vmode = 2;
        pulse_start(199);
        k = 0;
        while (op_idx < 50 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("t5_reach50", (op_idx >= 50) ? 1 : 0, 1);
        #2 rst_b = 1'b0;
        #1;
        check("t5_rst_sum", sum, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_ovf", ovf, 0);
        check("t5_rst_xready", x_ready, 0);
        @(negedge clk);
        #2 rst_b = 1'b1;
        ops[0] = 2; ops[1] = 3; ops[2] = 4;
        run_job(3, 1, 0, cyc);
        check("t5_sum", sum, 9);

        // start pulses during ACC and DONE are ignored
        for (int i = 0; i < 256; i++) ops[i] = $urandom_range(0, 1023);
        vmode = 2;
        pulse_start(20);
        repeat (5) @(negedge clk);
        start = 1'b1;
        n = CW'(7);
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done(1, cyc);
        check("t6_ops", op_idx, 20);
        repeat (3) @(negedge clk);
        check("t6_no_relaunch", busy, 0);

        // random jobs
        for (int j = 0; j < 6; j++) begin
            for (int i = 0; i < 256; i++) ops[i] = $urandom_range(0, 1023);
            run_job($urandom_range(0, 120), $urandom_range(0, 2), 0, cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mlop_seq_ctrl.md
Name: mlop_seq_ctrl

Overview:
- Sequencing controller plus accumulator for multi-operand addition.
- Accepts a job (start + term count n) and clears the accumulator.
- Pulls exactly n operands over a valid/ready handshake, adding each to the running sum.
- Signals done and holds the result until the next job; sits between an operand source (stream/ROM walker) and a result consumer.

Parameters:
- XW, 10, operand width.
- AW, 16, accumulator/result width.
- CW, 8, term-count width; max job length 2^CW-1.

Ports:
- clk  input  1  clock, rising edge.
- rst_b  input  1  reset, asynchronous, active-low.
- start  input  1  job request; sampled only in IDLE.
- n  input  CW  number of operands in the job; sampled with start.
- x_valid  input  1  operand present on x.
- x  input  XW  operand, unsigned.
- x_ready  output  1  controller accepts an operand this cycle.
- busy  output  1  job in progress (ACC state).
- done  output  1  one-cycle pulse: result final.
- sum  output  AW  accumulated result, unsigned modulo 2^AW.
- ovf  output  1  sticky: a carry out of bit AW-1 occurred during the current job.

Behaviour:
- Reset (rst_b=0, any time, including mid-job): state=IDLE, sum=0, ovf=0, cnt=0, x_ready=0, busy=0, done=0. Any job in flight is abandoned.
- States: IDLE, ACC, DONE (2-bit encoding).
- IDLE:
  - x_ready=0.
  - start=1 and n>0: sum<=0, ovf<=0, cnt<=n, go to ACC.
  - start=1 and n=0: sum<=0, ovf<=0, go to DONE.
  - start=0: stay; sum/ovf hold the previous result.
- ACC:
  - busy=1, x_ready=1 (combinational from state).
  - Handshake (x_valid & x_ready): {carry, sum}<=sum+x, with x zero-extended to AW+1; ovf<=ovf|carry; cnt<=cnt-1.
  - Handshake with cnt=1: go to DONE.
  - No x_valid: nothing changes; gaps of any length are allowed.
  - start is ignored in ACC.
- DONE: done=1 for exactly one cycle; x_ready=0; sum/ovf frozen; next state IDLE. A start in DONE is ignored; start is accepted no earlier than the following IDLE cycle.
- Timing:
  - First operand can be accepted in the cycle after start.
  - sum reflects an accepted operand one cycle after the handshake.
  - done asserts the cycle after the last handshake, with sum already final.
  - Minimum job length is n+2 cycles from the start edge to IDLE.
- Width rule: sum wraps modulo 2^AW; ovf records the wrap. cnt never underflows, because ACC is left at cnt=1.
- All outputs are registered except x_ready and busy, which are decoded from state.

Decomposition:
- Shared package mlop_pkg: state localparams (S_IDLE=0, S_ACC=1, S_DONE=2) and default widths XW/AW/CW.
- Sub-module: accumulator and count registers are instantiations of the team's generic load/clear register rgst.
  - Accumulator: rgst w=AW; clr=start accepted in IDLE; ld=handshake.
  - Count: rgst w=CW.
- FSM and ovf logic stay in mlop_seq_ctrl.

Test Plan:
- n=199, operands x=1,4,7,...,595 with x_valid held high → 199 handshakes, done pulse one cycle after the 199th, sum=59302, ovf=0, busy low after DONE.
- Same job with x_valid toggling 1,0,1,0 → identical sum=59302; cnt decrements only on handshakes; done arrives after ~2× the cycles.
- n=0 → no x_ready, done the cycle after DONE entry (start+1), sum=0, ovf=0.
- n=65, every x=1023 → sum=959 (66495 mod 65536), ovf=1; next job n=1, x=5 → sum=5, ovf=0.
- rst_b low after 50 operands of the 199-term job → immediately sum=0, busy=0, ovf=0, x_ready=0; a fresh start with n=3, x=2,3,4 gives sum=9.
- start pulsed with n=7 during ACC and during DONE → ignored; the original job completes with its own n, and no second job is launched.
